// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline header: stage indices, stall vector width and flush FSM encoding.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned StallWidth = 5;

  localparam int unsigned StageIf  = 0;
  localparam int unsigned StageId  = 1;
  localparam int unsigned StageEx  = 2;
  localparam int unsigned StageMem = 3;
  localparam int unsigned StageWb  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFlush = 2'b01,
    StDrain = 2'b10
  } flush_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Stall controller <-> pipeline signal bundle. The controller side is the master.
interface pipeline_stall_ctrl_if
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned McCntWidth = 6
) ();

  logic                  if_busy;
  logic                  id_hazard;
  logic                  ex_mc_start;
  logic [McCntWidth-1:0] ex_mc_cycles;
  logic                  mem_busy;
  logic                  exc_req;
  logic [AddrWidth-1:0]  exc_pc;

  logic [StallWidth-1:0] stall;
  logic                  flush;
  logic [AddrWidth-1:0]  flush_pc;
  logic                  fetch_discard;
  logic                  mc_busy;

  modport master (
    input  if_busy, id_hazard, ex_mc_start, ex_mc_cycles, mem_busy, exc_req, exc_pc,
    output stall, flush, flush_pc, fetch_discard, mc_busy
  );

  modport slave (
    output if_busy, id_hazard, ex_mc_start, ex_mc_cycles, mem_busy, exc_req, exc_pc,
    input  stall, flush, flush_pc, fetch_discard, mc_busy
  );

endinterface

// File: rtl/pipeline_stall_ctrl_mc_countdown.sv
// Multi-cycle EX occupancy counter: loads N-1, counts down to zero, clear dominates.
module mc_countdown #(
  parameter int unsigned CntWidth = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  output logic                busy_o,
  output logic                ge2_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Next count: a new load is only accepted once the previous op has drained.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntWidth'(1);
    end else if (load_i) begin
      cnt_d = load_val_i - CntWidth'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign ge2_o  = (cnt_q >= CntWidth'(2));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush generator for the five-stage pipeline.
// Optional build macro PIPE_STALL_CTRL_PERF_EN adds saturating stall/flush perf counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned McCntWidth = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef PIPE_STALL_CTRL_PERF_EN
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_flush_cnt_o,
`endif
  pipeline_stall_ctrl_if.master bus
);

  flush_state_e          state_q;
  logic                  flush_q;
  logic                  fetch_discard_q;
  logic [AddrWidth-1:0]  flush_pc_q;

  logic                  n_ge2;
  logic                  take_exc;
  logic                  mc_load;
  logic                  mc_busy;
  logic                  mc_ge2;
  logic [3:0]            req;
  logic [3:0]            req_eff;
  logic [StallWidth-1:0] stall;

  assign n_ge2    = (bus.ex_mc_cycles >= McCntWidth'(2));
  assign take_exc = (state_q == StIdle) && bus.exc_req && !bus.mem_busy;
  // A flush taken in the same cycle as a start wins: the op is never loaded.
  assign mc_load  = bus.ex_mc_start && n_ge2 && !take_exc;

  mc_countdown #(
    .CntWidth (McCntWidth)
  ) u_mc_countdown (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (state_q == StFlush),
    .load_i     (mc_load),
    .load_val_i (bus.ex_mc_cycles),
    .busy_o     (mc_busy),
    .ge2_o      (mc_ge2)
  );

  // Per-stage hold requests and the cumulative stall vector (downstream holds upstream).
  always_comb begin
    req[StageIf]  = bus.if_busy || (state_q == StDrain);
    req[StageId]  = bus.id_hazard;
    req[StageEx]  = (bus.ex_mc_start && n_ge2 && !mc_busy) || mc_ge2;
    req[StageMem] = bus.mem_busy;
    req_eff       = req;
    if (state_q == StFlush) begin
      req_eff[3:1] = 3'b000;
    end
    stall           = '0;
    stall[StageMem] = req_eff[3];
    stall[StageEx]  = |req_eff[3:2];
    stall[StageId]  = |req_eff[3:1];
    stall[StageIf]  = |req_eff[3:0];
    stall[StageWb]  = 1'b0;
  end

  // Flush sequencer with registered flush, target PC and fetch-discard outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
      fetch_discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take_exc) begin
            state_q    <= StFlush;
            flush_q    <= 1'b1;
            flush_pc_q <= bus.exc_pc;
          end
        end
        StFlush: begin
          flush_q <= 1'b0;
          if (bus.if_busy) begin
            state_q         <= StDrain;
            fetch_discard_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StDrain: begin
          // The fetch still in flight when flush hit must be dropped when it returns.
          if (!bus.if_busy) begin
            state_q         <= StIdle;
            fetch_discard_q <= 1'b0;
          end
        end
        default: begin
          state_q         <= StIdle;
          flush_q         <= 1'b0;
          fetch_discard_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall         = stall;
  assign bus.flush         = flush_q;
  assign bus.flush_pc      = flush_pc_q;
  assign bus.fetch_discard = fetch_discard_q;
  assign bus.mc_busy       = mc_busy;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_q;
  logic [31:0] perf_flush_cnt_q;

  // Saturating event counters: IF-stall cycles and FLUSH entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      if (stall[StageIf] && (perf_stall_cnt_q != '1)) begin
        perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
      end
      if (take_exc && (perf_flush_cnt_q != '1)) begin
        perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_q;
  assign perf_flush_cnt_o = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed, table-driven bench for pipeline_stall_ctrl.
// Honours PIPE_STALL_CTRL_PERF_EN to also exercise the perf counters.
module tb_pipeline_stall_ctrl;

  logic clk;
  logic rst_ni;
  int   tests;
  int   fails;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipeline_stall_ctrl_if #(.AddrWidth(32), .McCntWidth(6)) bus_if ();

  pipeline_stall_ctrl #(
    .AddrWidth  (32),
    .McCntWidth (6)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
`ifdef PIPE_STALL_CTRL_PERF_EN
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_flush_cnt_o (perf_flush_cnt),
`endif
    .bus              (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ib;
    logic        idh;
    logic        mcs;
    logic [5:0]  n;
    logic        mb;
    logic        exr;
    logic [31:0] pc;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] fpc;
    logic        disc;
    logic        mcb;
  } vec_t;

  localparam int NumVec = 27;
  vec_t vecs[NumVec];

  function automatic vec_t mk(logic ib, logic idh, logic mcs, logic [5:0] n, logic mb,
                              logic exr, logic [31:0] pc, logic [4:0] st, logic fl,
                              logic [31:0] fpc, logic disc, logic mcb);
    vec_t v;
    v.ib = ib; v.idh = idh; v.mcs = mcs; v.n = n; v.mb = mb; v.exr = exr; v.pc = pc;
    v.stall = st; v.flush = fl; v.fpc = fpc; v.disc = disc; v.mcb = mcb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ib, input logic idh, input logic mcs, input logic [5:0] n,
                       input logic mb, input logic exr, input logic [31:0] pc);
    bus_if.if_busy      = ib;
    bus_if.id_hazard    = idh;
    bus_if.ex_mc_start  = mcs;
    bus_if.ex_mc_cycles = n;
    bus_if.mem_busy     = mb;
    bus_if.exc_req      = exr;
    bus_if.exc_pc       = pc;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " stall"}, 32'(bus_if.stall), 32'h0);
    check({tag, " flush"}, 32'(bus_if.flush), 32'h0);
    check({tag, " flush_pc"}, bus_if.flush_pc, 32'h0);
    check({tag, " discard"}, 32'(bus_if.fetch_discard), 32'h0);
    check({tag, " mc_busy"}, 32'(bus_if.mc_busy), 32'h0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    // Each row is one clock cycle; expected values seen with those inputs applied.
    //            ib idh mcs  n  mb exr pc            stall     fl fpc           disc mcb
    vecs[0]  = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 0);
    vecs[1]  = mk(0, 0, 0, 6'd0, 1, 0, 32'h0,        5'b01111, 0, 32'h0,        0, 0);
    vecs[2]  = mk(0, 0, 0, 6'd0, 1, 0, 32'h0,        5'b01111, 0, 32'h0,        0, 0);
    vecs[3]  = mk(0, 0, 0, 6'd0, 1, 0, 32'h0,        5'b01111, 0, 32'h0,        0, 0);
    vecs[4]  = mk(0, 1, 0, 6'd0, 0, 0, 32'h0,        5'b00011, 0, 32'h0,        0, 0);
    vecs[5]  = mk(1, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00001, 0, 32'h0,        0, 0);
    vecs[6]  = mk(0, 0, 1, 6'd4, 0, 0, 32'h0,        5'b00111, 0, 32'h0,        0, 0);
    vecs[7]  = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00111, 0, 32'h0,        0, 1);
    vecs[8]  = mk(0, 0, 1, 6'd5, 0, 0, 32'h0,        5'b00111, 0, 32'h0,        0, 1);
    vecs[9]  = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 1);
    vecs[10] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 0);
    vecs[11] = mk(0, 0, 1, 6'd1, 0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 0);
    vecs[12] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 0);
    vecs[13] = mk(0, 0, 0, 6'd0, 0, 1, 32'hBFC00380, 5'b00000, 0, 32'h0,        0, 0);
    vecs[14] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 1, 32'hBFC00380, 0, 0);
    vecs[15] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'hBFC00380, 0, 0);
    vecs[16] = mk(0, 0, 0, 6'd0, 1, 1, 32'h80000180, 5'b01111, 0, 32'hBFC00380, 0, 0);
    vecs[17] = mk(0, 0, 0, 6'd0, 1, 1, 32'h80000180, 5'b01111, 0, 32'hBFC00380, 0, 0);
    vecs[18] = mk(0, 0, 0, 6'd0, 0, 1, 32'h80000180, 5'b00000, 0, 32'hBFC00380, 0, 0);
    vecs[19] = mk(1, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00001, 1, 32'h80000180, 0, 0);
    vecs[20] = mk(1, 0, 0, 6'd0, 0, 1, 32'hDEADBEEF, 5'b00001, 0, 32'h80000180, 1, 0);
    vecs[21] = mk(1, 0, 0, 6'd0, 0, 1, 32'hDEADBEEF, 5'b00001, 0, 32'h80000180, 1, 0);
    vecs[22] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00001, 0, 32'h80000180, 1, 0);
    vecs[23] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'h80000180, 0, 0);
    vecs[24] = mk(0, 0, 1, 6'd4, 0, 1, 32'h00001000, 5'b00111, 0, 32'h80000180, 0, 0);
    vecs[25] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 1, 32'h00001000, 0, 0);
    vecs[26] = mk(0, 0, 0, 6'd0, 0, 0, 32'h0,        5'b00000, 0, 32'h00001000, 0, 0);

    // Reset with all inputs idle.
    rst_ni = 1'b0;
    drive(0, 0, 0, 6'd0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vecs[i].ib, vecs[i].idh, vecs[i].mcs, vecs[i].n, vecs[i].mb, vecs[i].exr,
            vecs[i].pc);
      #1;
      check($sformatf("row%0d stall", i), 32'(bus_if.stall), 32'(vecs[i].stall));
      check($sformatf("row%0d flush", i), 32'(bus_if.flush), 32'(vecs[i].flush));
      check($sformatf("row%0d flush_pc", i), bus_if.flush_pc, vecs[i].fpc);
      check($sformatf("row%0d discard", i), 32'(bus_if.fetch_discard), 32'(vecs[i].disc));
      check($sformatf("row%0d mc_busy", i), 32'(bus_if.mc_busy), 32'(vecs[i].mcb));
    end

    // Reset asserted mid-DRAIN aborts immediately.
    @(negedge clk);
    drive(0, 0, 0, 6'd0, 0, 1, 32'h12345678);
    @(negedge clk);
    drive(1, 0, 0, 6'd0, 0, 0, 32'h0);
    #1;
    check("drain-seq flush", 32'(bus_if.flush), 32'h1);
    @(negedge clk);
    #1;
    check("drain-seq discard", 32'(bus_if.fetch_discard), 32'h1);
    drive(0, 0, 0, 6'd0, 0, 0, 32'h0);
    rst_ni = 1'b0;
    #1;
    check_reset_vals("rst-in-drain");
    @(negedge clk);
    rst_ni = 1'b1;

    // Reset asserted mid-count aborts immediately.
    @(negedge clk);
    drive(0, 0, 1, 6'd10, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 6'd0, 0, 0, 32'h0);
    #1;
    check("count-seq mc_busy", 32'(bus_if.mc_busy), 32'h1);
    check("count-seq stall", 32'(bus_if.stall), 32'h7);
    rst_ni = 1'b0;
    #1;
    check_reset_vals("rst-in-count");
    @(negedge clk);
    rst_ni = 1'b1;

    // A flush in progress does not survive reset.
    @(negedge clk);
    drive(0, 0, 0, 6'd0, 0, 1, 32'hCAFE0000);
    @(negedge clk);
    drive(0, 0, 0, 6'd0, 0, 0, 32'h0);
    #1;
    check("pend-seq flush", 32'(bus_if.flush), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("pend-seq flush in reset", 32'(bus_if.flush), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    check("pend-seq flush after reset", 32'(bus_if.flush), 32'h0);
    check("pend-seq flush_pc after reset", bus_if.flush_pc, 32'h0);

`ifdef PIPE_STALL_CTRL_PERF_EN
    // 10 IF-stall cycles and 2 flushes from a fresh reset.
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check("perf stall at reset", perf_stall_cnt, 32'd0);
    check("perf flush at reset", perf_flush_cnt, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1, 0, 0, 6'd0, 0, 0, 32'h0);
    end
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      drive(0, 0, 0, 6'd0, 0, 1, 32'h00000100);
      repeat (2) begin
        @(negedge clk);
        drive(0, 0, 0, 6'd0, 0, 0, 32'h0);
      end
    end
    @(negedge clk);
    #1;
    check("perf stall count", perf_stall_cnt, 32'd10);
    check("perf flush count", perf_flush_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush generator for the five-stage core (IF, ID, EX, MEM, WB). It collects per-stage hold requests, times multi-cycle EX operations, and sequences exception/return flushes. It drives the per-stage `stall` vector consumed by every inter-stage pipeline register, which inserts a bubble wherever a stage stalls while its successor does not.

## Interface
- `ADDR_WIDTH`, 32, width of the flush target PC
- `MC_CNT_WIDTH`, 6, width of the multi-cycle operation length field
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `if_busy`  in  1  instruction-fetch bus transaction outstanding
- `id_hazard`  in  1  load-use hazard detected in ID
- `ex_mc_start`  in  1  EX begins a multi-cycle operation (mul/div)
- `ex_mc_cycles`  in  MC_CNT_WIDTH  total EX occupancy N of that operation, in cycles
- `mem_busy`  in  1  data bus transaction outstanding in MEM
- `exc_req`  in  1  flush request from MEM (exception/eret); held by requester until taken
- `exc_pc`  in  ADDR_WIDTH  flush target PC
- `stall`  out  5  per-stage hold; bit 0 = IF … bit 4 = WB
- `flush`  out  1  one-cycle flush pulse to all stage registers and PC
- `flush_pc`  out  ADDR_WIDTH  registered target, valid while `flush` = 1
- `fetch_discard`  out  1  the returning fetch must be dropped
- `mc_busy`  out  1  multi-cycle counter non-zero

## Operation
- Request vector: `r0` = `if_busy` | (state == DRAIN); `r1` = `id_hazard`; `r2` = (`ex_mc_start` & N ≥ 2 & cnt == 0) | (cnt ≥ 2); `r3` = `mem_busy`.
- `stall[i]` = OR of `r[j]` for j ≥ i, i = 0..3. `stall[4]` is constant 0.
- Multi-cycle counter `cnt`:
  - When cnt == 0, `ex_mc_start` with N ≥ 2 loads N−1.
  - `ex_mc_start` is ignored while cnt ≠ 0.
  - cnt decrements each cycle while non-zero.
  - N = 0 or 1 produces no stall.
- Flush FSM states:
  - IDLE → FLUSH when `exc_req` = 1 and `mem_busy` = 0. `exc_pc` is latched into `flush_pc`. `exc_req` is not taken while `mem_busy` = 1.
  - FLUSH: `flush` = 1 and cnt is cleared. Next state is DRAIN if `if_busy` = 1, otherwise IDLE.
  - DRAIN: `fetch_discard` = 1 and stall[0] is held. Returns to IDLE in the cycle after `if_busy` = 0.
  - `exc_req` is ignored outside IDLE.
- In the FLUSH cycle, `stall[3:1]` = 0 regardless of requests, because flush dominates.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, cnt = 0, `flush` = 0, `flush_pc` = 0, `fetch_discard` = 0, `mc_busy` = 0.
- `stall` is combinational from inputs and registered state, with zero latency. `flush` and `flush_pc` are registered, with one-cycle latency from the taking of `exc_req`.
- An op of length N stalls EX (and upstream stages) for exactly N−1 cycles, starting in the start cycle.
- If `exc_req` and `ex_mc_start` arrive together, the flush wins and cnt is not loaded.
- Reset asserted mid-DRAIN or mid-count aborts immediately. No pending flush survives reset.

## Configuration
- `PIPE_STALL_CTRL_PERF_EN` defined adds two output ports:
  - `perf_stall_cnt` (32): cycles with stall[0] = 1.
  - `perf_flush_cnt` (32): FLUSH entries.
  - Both saturate at all-ones and reset to 0.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared pipeline header: stage index constants (`STAGE_IF`…`STAGE_WB`), FSM state encodings (IDLE/FLUSH/DRAIN), and stall vector width 5.
- One sub-module, `mc_countdown`, holds the load/decrement counter and produces `cnt ≥ 2` and `cnt ≠ 0`.

## Test plan
- Reset with all inputs 0 → `stall` = 5'b00000, `flush` = 0, `mc_busy` = 0. Assert `rst` = 0 mid-DRAIN → outputs return to reset values the same cycle.
- `mem_busy` = 1 for 3 cycles → `stall` = 5'b01111 for those 3 cycles. `id_hazard` alone → 5'b00011.
- `ex_mc_start` with N = 4 → `stall` = 5'b00111 for 3 cycles, starting in the start cycle. `mc_busy` high for 3 cycles. A second start during busy is ignored. N = 1 → no stall.
- `exc_req` with `exc_pc` = 0xBFC00380 and `if_busy` = 0 → next cycle `flush` = 1 and `flush_pc` = 0xBFC00380, then IDLE. The same request with `mem_busy` = 1 is not taken until `mem_busy` falls.
- `exc_req` taken with `if_busy` = 1 for 2 further cycles → FLUSH, then DRAIN with `fetch_discard` = 1 and stall[0] = 1 until `if_busy` falls, then IDLE.
- With `PIPE_STALL_CTRL_PERF_EN` defined: 10 IF-stall cycles and 2 flushes → `perf_stall_cnt` = 10, `perf_flush_cnt` = 2.
